// File: rtl/hsid_x_reg_initiator.sv
// HSpecID-X register-bus initiator.
// Runs one job over the accelerator register port: programs the job
// configuration, pulses start, polls STATUS, reads back the MSE min/max
// results and hands them over on a result handshake.
module hsid_x_reg_initiator #(
    parameter int          WORD_WIDTH        = 32,
    parameter int          HSP_BANDS_WIDTH   = 16,
    parameter int          HSP_LIBRARY_WIDTH = 16,
    parameter logic [31:0] BASE_ADDR         = 32'h0000_0000,
    parameter int          POLL_LIMIT        = 1024
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [HSP_LIBRARY_WIDTH-1:0] cmd_library_size,
    input  logic [HSP_BANDS_WIDTH-1:0]   cmd_pixel_bands,
    input  logic [WORD_WIDTH-1:0]        cmd_captured_addr,
    input  logic [WORD_WIDTH-1:0]        cmd_library_addr,
    input  logic                         abort,
    output logic                         reg_valid,
    output logic                         reg_write,
    output logic [31:0]                  reg_addr,
    output logic [WORD_WIDTH-1:0]        reg_wdata,
    output logic [WORD_WIDTH/8-1:0]      reg_wstrb,
    input  logic                         reg_ready,
    input  logic [WORD_WIDTH-1:0]        reg_rdata,
    input  logic                         reg_error,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic [2:0]                   res_code,
    output logic [HSP_LIBRARY_WIDTH-1:0] res_mse_min_ref,
    output logic [WORD_WIDTH-1:0]        res_mse_min_value,
    output logic [HSP_LIBRARY_WIDTH-1:0] res_mse_max_ref,
    output logic [WORD_WIDTH-1:0]        res_mse_max_value
);

    localparam int STRB_WIDTH = WORD_WIDTH / 8;
    localparam int CNT_WIDTH  = $clog2(POLL_LIMIT + 1);

    // Register offsets from BASE_ADDR
    localparam logic [31:0] OFF_CTRL      = 32'h0000_0000;
    localparam logic [31:0] OFF_STATUS    = 32'h0000_0004;
    localparam logic [31:0] OFF_LIB_SIZE  = 32'h0000_0008;
    localparam logic [31:0] OFF_BANDS     = 32'h0000_000C;
    localparam logic [31:0] OFF_CAP_ADDR  = 32'h0000_0010;
    localparam logic [31:0] OFF_LIB_ADDR  = 32'h0000_0014;
    localparam logic [31:0] OFF_MIN_REF   = 32'h0000_0018;
    localparam logic [31:0] OFF_MIN_VALUE = 32'h0000_001C;
    localparam logic [31:0] OFF_MAX_REF   = 32'h0000_0020;
    localparam logic [31:0] OFF_MAX_VALUE = 32'h0000_0024;

    // Result codes
    localparam logic [2:0] CODE_DONE      = 3'd0;
    localparam logic [2:0] CODE_HW_ERROR  = 3'd1;
    localparam logic [2:0] CODE_CANCELLED = 3'd2;
    localparam logic [2:0] CODE_BUS_ERROR = 3'd3;
    localparam logic [2:0] CODE_TIMEOUT   = 3'd4;

    typedef enum logic [3:0] {
        S_IDLE, S_WR_LIB, S_WR_BANDS, S_WR_CAP, S_WR_LADDR, S_WR_START,
        S_POLL, S_RD_MINREF, S_RD_MINVAL, S_RD_MAXREF, S_RD_MAXVAL,
        S_WR_CLEAR, S_RESP
    } state_t;

    // One bus request, held as a single register so all fields move together
    typedef struct packed {
        logic                  valid;
        logic                  write;
        logic [31:0]           addr;
        logic [WORD_WIDTH-1:0] wdata;
        logic [STRB_WIDTH-1:0] wstrb;
    } req_t;

    function automatic req_t no_req();
        req_t r;
        r.valid = 1'b0;
        r.write = 1'b0;
        r.addr  = 32'h0000_0000;
        r.wdata = {WORD_WIDTH{1'b0}};
        r.wstrb = {STRB_WIDTH{1'b0}};
        return r;
    endfunction

    function automatic req_t wr_req(input logic [31:0] off, input logic [WORD_WIDTH-1:0] data);
        req_t r;
        r.valid = 1'b1;
        r.write = 1'b1;
        r.addr  = BASE_ADDR + off;
        r.wdata = data;
        r.wstrb = {STRB_WIDTH{1'b1}};
        return r;
    endfunction

    function automatic req_t rd_req(input logic [31:0] off);
        req_t r;
        r.valid = 1'b1;
        r.write = 1'b0;
        r.addr  = BASE_ADDR + off;
        r.wdata = {WORD_WIDTH{1'b0}};
        r.wstrb = {STRB_WIDTH{1'b0}};
        return r;
    endfunction

    state_t                       state_r;
    req_t                         req_r;
    logic [HSP_BANDS_WIDTH-1:0]   bands_r;
    logic [WORD_WIDTH-1:0]        cap_addr_r;
    logic [WORD_WIDTH-1:0]        lib_addr_r;
    logic [CNT_WIDTH-1:0]         poll_cnt_r;
    logic                         cmd_ready_r;
    logic                         res_valid_r;
    logic [2:0]                   res_code_r;
    logic [HSP_LIBRARY_WIDTH-1:0] min_ref_r;
    logic [WORD_WIDTH-1:0]        min_value_r;
    logic [HSP_LIBRARY_WIDTH-1:0] max_ref_r;
    logic [WORD_WIDTH-1:0]        max_value_r;
    logic                         xfer_done_s;

    // A transfer completes when our held request meets the responder's ready
    assign xfer_done_s = req_r.valid & reg_ready;

    assign cmd_ready         = cmd_ready_r;
    assign reg_valid         = req_r.valid;
    assign reg_write         = req_r.write;
    assign reg_addr          = req_r.addr;
    assign reg_wdata         = req_r.wdata;
    assign reg_wstrb         = req_r.wstrb;
    assign res_valid         = res_valid_r;
    assign res_code          = res_code_r;
    assign res_mse_min_ref   = min_ref_r;
    assign res_mse_min_value = min_value_r;
    assign res_mse_max_ref   = max_ref_r;
    assign res_mse_max_value = max_value_r;

    // Job sequencer: the next request is loaded on the completion edge of the current one
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= S_IDLE;
            req_r       <= no_req();
            bands_r     <= {HSP_BANDS_WIDTH{1'b0}};
            cap_addr_r  <= {WORD_WIDTH{1'b0}};
            lib_addr_r  <= {WORD_WIDTH{1'b0}};
            poll_cnt_r  <= {CNT_WIDTH{1'b0}};
            cmd_ready_r <= 1'b1;
            res_valid_r <= 1'b0;
            res_code_r  <= CODE_DONE;
            min_ref_r   <= {HSP_LIBRARY_WIDTH{1'b0}};
            min_value_r <= {WORD_WIDTH{1'b0}};
            max_ref_r   <= {HSP_LIBRARY_WIDTH{1'b0}};
            max_value_r <= {WORD_WIDTH{1'b0}};
        end else if (xfer_done_s && reg_error) begin
            // Any failed transfer ends the job; partial MSE reads are discarded
            state_r     <= S_RESP;
            req_r       <= no_req();
            res_valid_r <= 1'b1;
            res_code_r  <= CODE_BUS_ERROR;
            min_ref_r   <= {HSP_LIBRARY_WIDTH{1'b0}};
            min_value_r <= {WORD_WIDTH{1'b0}};
            max_ref_r   <= {HSP_LIBRARY_WIDTH{1'b0}};
            max_value_r <= {WORD_WIDTH{1'b0}};
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (cmd_valid) begin
                        // Library size goes straight out; the rest is kept for later writes
                        bands_r     <= cmd_pixel_bands;
                        cap_addr_r  <= cmd_captured_addr;
                        lib_addr_r  <= cmd_library_addr;
                        poll_cnt_r  <= {CNT_WIDTH{1'b0}};
                        cmd_ready_r <= 1'b0;
                        min_ref_r   <= {HSP_LIBRARY_WIDTH{1'b0}};
                        min_value_r <= {WORD_WIDTH{1'b0}};
                        max_ref_r   <= {HSP_LIBRARY_WIDTH{1'b0}};
                        max_value_r <= {WORD_WIDTH{1'b0}};
                        req_r       <= wr_req(OFF_LIB_SIZE, WORD_WIDTH'(cmd_library_size));
                        state_r     <= S_WR_LIB;
                    end else begin
                        cmd_ready_r <= 1'b1;
                    end
                end
                S_WR_LIB: if (xfer_done_s) begin
                    req_r   <= wr_req(OFF_BANDS, WORD_WIDTH'(bands_r));
                    state_r <= S_WR_BANDS;
                end
                S_WR_BANDS: if (xfer_done_s) begin
                    req_r   <= wr_req(OFF_CAP_ADDR, cap_addr_r);
                    state_r <= S_WR_CAP;
                end
                S_WR_CAP: if (xfer_done_s) begin
                    req_r   <= wr_req(OFF_LIB_ADDR, lib_addr_r);
                    state_r <= S_WR_LADDR;
                end
                S_WR_LADDR: if (xfer_done_s) begin
                    req_r   <= wr_req(OFF_CTRL, WORD_WIDTH'(2'b01));
                    state_r <= S_WR_START;
                end
                S_WR_START: if (xfer_done_s) begin
                    req_r   <= rd_req(OFF_STATUS);
                    state_r <= S_POLL;
                end
                S_POLL: begin
                    if (xfer_done_s) begin
                        // Status priority: done, then error, then cancelled
                        if (reg_rdata[2]) begin
                            req_r   <= rd_req(OFF_MIN_REF);
                            state_r <= S_RD_MINREF;
                        end else if (reg_rdata[3]) begin
                            req_r       <= no_req();
                            res_valid_r <= 1'b1;
                            res_code_r  <= CODE_HW_ERROR;
                            state_r     <= S_RESP;
                        end else if (reg_rdata[4]) begin
                            req_r       <= no_req();
                            res_valid_r <= 1'b1;
                            res_code_r  <= CODE_CANCELLED;
                            state_r     <= S_RESP;
                        end else if ((poll_cnt_r + CNT_WIDTH'(1)) == CNT_WIDTH'(POLL_LIMIT)) begin
                            poll_cnt_r  <= poll_cnt_r + CNT_WIDTH'(1);
                            req_r       <= no_req();
                            res_valid_r <= 1'b1;
                            res_code_r  <= CODE_TIMEOUT;
                            state_r     <= S_RESP;
                        end else begin
                            // Keep the STATUS read asserted for another poll
                            poll_cnt_r <= poll_cnt_r + CNT_WIDTH'(1);
                        end
                    end else if (abort) begin
                        // Abandon the pending poll and clear the accelerator
                        req_r   <= wr_req(OFF_CTRL, WORD_WIDTH'(2'b10));
                        state_r <= S_WR_CLEAR;
                    end
                end
                S_RD_MINREF: if (xfer_done_s) begin
                    min_ref_r <= reg_rdata[HSP_LIBRARY_WIDTH-1:0];
                    req_r     <= rd_req(OFF_MIN_VALUE);
                    state_r   <= S_RD_MINVAL;
                end
                S_RD_MINVAL: if (xfer_done_s) begin
                    min_value_r <= reg_rdata;
                    req_r       <= rd_req(OFF_MAX_REF);
                    state_r     <= S_RD_MAXREF;
                end
                S_RD_MAXREF: if (xfer_done_s) begin
                    max_ref_r <= reg_rdata[HSP_LIBRARY_WIDTH-1:0];
                    req_r     <= rd_req(OFF_MAX_VALUE);
                    state_r   <= S_RD_MAXVAL;
                end
                S_RD_MAXVAL: if (xfer_done_s) begin
                    max_value_r <= reg_rdata;
                    req_r       <= no_req();
                    res_valid_r <= 1'b1;
                    res_code_r  <= CODE_DONE;
                    state_r     <= S_RESP;
                end
                S_WR_CLEAR: if (xfer_done_s) begin
                    req_r       <= no_req();
                    res_valid_r <= 1'b1;
                    res_code_r  <= CODE_CANCELLED;
                    state_r     <= S_RESP;
                end
                S_RESP: if (res_ready) begin
                    res_valid_r <= 1'b0;
                    cmd_ready_r <= 1'b1;
                    poll_cnt_r  <= {CNT_WIDTH{1'b0}};
                    state_r     <= S_IDLE;
                end
                default: begin
                    state_r     <= S_IDLE;
                    req_r       <= no_req();
                    cmd_ready_r <= 1'b1;
                    res_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule
